// File: rtl/nn_pkg.sv
// nn_pkg
// Shared definitions for the neural-network datapath blocks: fixed-point
// format constants, default operand widths and the neuron control states.
// No ports; imported by nn_mac_unit and output_neuron.
package nn_pkg;

  // Fractional bit counts of the fixed-point formats in use.
  localparam int FRAC_H   = 7;   // hidden activation, unsigned Q3.7
  localparam int FRAC_W   = 7;   // weight, signed Q1.7
  localparam int FRAC_ACC = 14;  // accumulator, signed Q6.14

  // Default geometry of the output neuron.
  localparam int DEF_N_IN  = 4;
  localparam int DEF_HW    = 10;
  localparam int DEF_WW    = 8;
  localparam int DEF_ACC_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } neuron_state_t;

endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit
// Combinational multiply-accumulate step: sum = acc + sext(zext(h) * w).
// The activation is unsigned and the weight signed, so the activation gets
// one leading zero bit before a signed multiply, giving an exact
// (HW+WW+1)-bit signed product that is sign-extended into the accumulator.
// Ports:
//   acc_i  in  ACC_W  signed running sum
//   h_i    in  HW     unsigned activation
//   w_i    in  WW     signed weight
//   sum_o  out ACC_W  signed acc_i + product
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int HW    = DEF_HW,
  parameter int WW    = DEF_WW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [HW-1:0]    h_i,
  input  logic signed [WW-1:0]    w_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [HW:0]       h_ext_s;
  logic signed [HW+WW:0]    prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;

  // Zero-extend so the activation is never read as negative.
  assign h_ext_s    = $signed({1'b0, h_i});
  assign prod_s     = h_ext_s * w_i;
  assign prod_ext_s = ACC_W'(prod_s);
  assign sum_o      = acc_i + prod_ext_s;

endmodule

// File: rtl/output_neuron.sv
// output_neuron
// Sequential output-layer neuron. On start it snapshots the hidden-layer
// activations, weights and threshold, loads the bias into the accumulator,
// then performs one multiply-accumulate per clock. After the last term it
// latches the sum and the class decision (sum > threshold, signed) and
// pulses done for one cycle.
// Ports:
//   clk_i     in   1          rising-edge clock
//   rst_i     in   1          asynchronous active-high reset
//   start_i   in   1          start request, sampled only when idle
//   h_i       in   N_IN*HW    packed unsigned activations, element k at [k*HW +: HW]
//   w_i       in   N_IN*WW    packed signed weights, element k at [k*WW +: WW]
//   bias_i    in   ACC_W      signed bias, Q6.14
//   thresh_i  in   ACC_W      signed decision threshold, Q6.14
//   busy_o    out  1          high while computing and during the done cycle
//   done_o    out  1          one-cycle completion pulse
//   sum_o     out  ACC_W      signed result of the last completed computation
//   class_o   out  1          1 when sum_o > threshold, latched at completion
module output_neuron
  import nn_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int HW    = DEF_HW,
  parameter int WW    = DEF_WW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [N_IN*HW-1:0] h_i,
  input  logic [N_IN*WW-1:0] w_i,
  input  logic [ACC_W-1:0]   bias_i,
  input  logic [ACC_W-1:0]   thresh_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ACC_W-1:0]   sum_o,
  output logic               class_o
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  // The accumulator must hold the full product plus the growth from
  // summing N_IN terms; the bias is expected to stay within half range.
  if (ACC_W < HW + WW + 1 + $clog2(N_IN)) begin : g_acc_w_check
    $error("output_neuron: ACC_W too small for HW, WW and N_IN");
  end

  neuron_state_t            state_r;
  logic [IDX_W-1:0]         idx_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  thresh_r;
  logic [HW-1:0]            h_r [N_IN];
  logic signed [WW-1:0]     w_r [N_IN];
  logic                     busy_r;
  logic                     done_r;
  logic signed [ACC_W-1:0]  sum_r;
  logic                     class_r;
  logic signed [ACC_W-1:0]  mac_sum_s;
  logic                     last_s;

  nn_mac_unit #(
    .HW    (HW),
    .WW    (WW),
    .ACC_W (ACC_W)
  ) u_mac (
    .acc_i (acc_r),
    .h_i   (h_r[idx_r]),
    .w_i   (w_r[idx_r]),
    .sum_o (mac_sum_s)
  );

  assign last_s = (idx_r == IDX_W'(N_IN - 1));

  // Control FSM, operand snapshot, accumulator and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      acc_r    <= '0;
      thresh_r <= '0;
      for (int k = 0; k < N_IN; k++) begin
        h_r[k] <= '0;
        w_r[k] <= '0;
      end
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= '0;
      class_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            // Snapshot operands so later input changes cannot disturb the run.
            for (int k = 0; k < N_IN; k++) begin
              h_r[k] <= h_i[k*HW +: HW];
              w_r[k] <= $signed(w_i[k*WW +: WW]);
            end
            thresh_r <= $signed(thresh_i);
            acc_r    <= $signed(bias_i);
            idx_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= MAC;
          end else begin
            busy_r <= 1'b0;
          end
        end
        MAC: begin
          acc_r <= mac_sum_s;
          if (last_s) begin
            // Last term: publish the full sum and the decision together.
            sum_r   <= mac_sum_s;
            class_r <= (mac_sum_s > thresh_r);
            done_r  <= 1'b1;
            idx_r   <= '0;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          idx_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign sum_o   = sum_r;
  assign class_o = class_r;

endmodule

// File: tb/tb_output_neuron.sv
// tb_output_neuron
// Directed self-checking bench for output_neuron with hand-computed sums.
// Inputs are driven just after the rising edge or on the falling edge;
// outputs are sampled on the falling edge.
module tb_output_neuron;

  localparam int N_IN  = 4;
  localparam int HW    = 10;
  localparam int WW    = 8;
  localparam int ACC_W = 21;

  logic               clk_i;
  logic               rst_i;
  logic               start_i;
  logic [N_IN*HW-1:0] h_i;
  logic [N_IN*WW-1:0] w_i;
  logic [ACC_W-1:0]   bias_i;
  logic [ACC_W-1:0]   thresh_i;
  logic               busy_o;
  logic               done_o;
  logic [ACC_W-1:0]   sum_o;
  logic               class_o;

  int err_cnt;
  int chk_cnt;

  output_neuron #(
    .N_IN  (N_IN),
    .HW    (HW),
    .WW    (WW),
    .ACC_W (ACC_W)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .h_i      (h_i),
    .w_i      (w_i),
    .bias_i   (bias_i),
    .thresh_i (thresh_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .sum_o    (sum_o),
    .class_o  (class_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int sum_int();
    logic signed [ACC_W-1:0] s;
    s = $signed(sum_o);
    return int'(s);
  endfunction

  task automatic set_inputs(input logic [N_IN*HW-1:0] h, input logic [N_IN*WW-1:0] w,
                            input int bias, input int thresh);
    h_i      = h;
    w_i      = w;
    bias_i   = 21'(bias);
    thresh_i = 21'(thresh);
  endtask

  // One computation: start pulse, bounded wait for done, then check timing and result.
  task automatic do_op(input string tag, input logic [N_IN*HW-1:0] h,
                       input logic [N_IN*WW-1:0] w, input int bias, input int thresh,
                       input int exp_sum, input int exp_cls);
    int cyc;
    int busy_cnt;
    @(negedge clk_i);
    set_inputs(h, w, bias, thresh);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      cyc = n;
      if (busy_o) busy_cnt++;
      if (done_o) break;
    end
    check_val({tag, "_latency"}, cyc, 5);
    check_val({tag, "_busy_cycles"}, busy_cnt, 5);
    check_val({tag, "_sum"}, sum_int(), exp_sum);
    check_val({tag, "_class"}, int'(class_o), exp_cls);
    @(negedge clk_i);
    check_val({tag, "_done_one_cycle"}, int'(done_o), 0);
    check_val({tag, "_busy_released"}, int'(busy_o), 0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    int dn[$];
    err_cnt  = 0;
    chk_cnt  = 0;
    rst_i    = 1'b1;
    start_i  = 1'b0;
    set_inputs('0, '0, 0, 0);
    repeat (2) @(negedge clk_i);
    check_val("rst_busy", int'(busy_o), 0);
    check_val("rst_done", int'(done_o), 0);
    check_val("rst_sum", sum_int(), 0);
    check_val("rst_class", int'(class_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 128*64 twice = 16384 (1.0 in Q6.14)
    do_op("unity", {10'd0, 10'd0, 10'd128, 10'd128}, {8'd0, 8'd0, 8'd64, 8'd64},
          0, 0, 16384, 1);
    // 4 * 128 * -128
    do_op("negw", {4{10'd128}}, {4{8'h80}}, 0, 0, -65536, 0);
    // 4 * 1023 * 127 and 4 * 1023 * -128
    do_op("ext_pos", {4{10'd1023}}, {4{8'h7F}}, 0, 0, 519684, 1);
    do_op("ext_neg", {4{10'd1023}}, {4{8'h80}}, 0, 0, -523776, 0);
    // Bias only, equal threshold is not greater
    do_op("tie", '0, {4{8'h7F}}, 12345, 12345, 12345, 0);
    do_op("tie_m1", '0, {4{8'h7F}}, 12345, 12344, 12345, 1);
    // 7*5 + 1000*-20 + 50*100 + 300*-3 - 1000 = -16865 > -20000
    do_op("mixed", {10'd300, 10'd50, 10'd1000, 10'd7}, {8'hFD, 8'h64, 8'hEC, 8'h05},
          -1000, -20000, -16865, 1);

    // Inputs changed and start pulsed during MAC must not affect the run.
    @(negedge clk_i);
    set_inputs({10'd0, 10'd0, 10'd128, 10'd128}, {8'd0, 8'd0, 8'd64, 8'd64}, 0, 0);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    set_inputs({4{10'd1023}}, {4{8'h7F}}, 5000, 900000);
    @(posedge clk_i);
    #1 start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    cyc = 0;
    for (int n = 3; n <= 20; n++) begin
      @(negedge clk_i);
      cyc = n;
      if (done_o) break;
    end
    check_val("isolate_latency", cyc, 5);
    check_val("isolate_sum", sum_int(), 16384);
    check_val("isolate_class", int'(class_o), 1);
    repeat (2) @(negedge clk_i);
    check_val("mac_start_not_queued", int'(busy_o), 0);

    // Start held high: done every 6 cycles.
    @(negedge clk_i);
    set_inputs({10'd0, 10'd0, 10'd128, 10'd128}, {8'd0, 8'd0, 8'd64, 8'd64}, 0, 0);
    start_i = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (done_o) dn.push_back(n);
    end
    start_i = 1'b0;
    check_val("hold_pulses", dn.size(), 3);
    if (dn.size() >= 3) begin
      check_val("hold_first", dn[0], 5);
      check_val("hold_gap1", dn[1] - dn[0], 6);
      check_val("hold_gap2", dn[2] - dn[1], 6);
    end
    check_val("hold_sum", sum_int(), 16384);
    repeat (8) @(negedge clk_i);
    check_val("hold_release_idle", int'(busy_o), 0);

    // Reset during MAC at idx=2: immediate clear, no done pulse.
    @(negedge clk_i);
    set_inputs({4{10'd1023}}, {4{8'h7F}}, 0, 0);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check_val("arst_busy", int'(busy_o), 0);
    check_val("arst_sum", sum_int(), 0);
    check_val("arst_class", int'(class_o), 0);
    done_seen = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (done_o || busy_o) done_seen++;
    end
    check_val("arst_no_done", done_seen, 0);
    do_op("post_rst", {10'd300, 10'd50, 10'd1000, 10'd7}, {8'hFD, 8'h64, 8'hEC, 8'h05},
          -1000, -20000, -16865, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
